// File: rtl/stream_burst_tx.sv
// Buffered burst transmitter: samples are queued in a circular buffer and
// replayed as a registered val_o/dat_o stream with an optional idle gap.
module stream_burst_tx #(
  parameter int WORD_LEN = 8,
  parameter int DEPTH    = 16,
  parameter int AW       = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [WORD_LEN-1:0] wr_dat,
  output logic                full,
  output logic [AW:0]         level,
  input  logic                start,
  input  logic [AW:0]         len,
  input  logic [3:0]          gap,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                ovf,
  output logic [WORD_LEN-1:0] dat_o,
  output logic                val_o
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t              state_q, state_d;
  logic [WORD_LEN-1:0] mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]         level_q, level_d, rem_q, rem_d;
  logic [3:0]          gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic                full_q, full_d, busy_q, busy_d, done_q, done_d;
  logic                err_q, err_d, ovf_q, ovf_d, val_q, val_d;
  logic [WORD_LEN-1:0] dat_q, dat_d;
  logic                pop, wr_ok;

  always_comb begin
    pop       = (state_q == SEND);
    // A full buffer still accepts a write when a pop frees a slot on the same edge.
    wr_ok     = wr_en && (!full_q || pop);
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rem_d     = rem_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    val_d     = 1'b0;
    dat_d     = '0;
    ovf_d     = ovf_q | (wr_en & ~wr_ok);

    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
    level_d = level_q + (AW+1)'(wr_ok) - (AW+1)'(pop);
    full_d  = (level_d == (AW+1)'(DEPTH));

    case (state_q)
      IDLE: begin
        if (start && !busy_q) begin
          if ((len != '0) && (len <= level_q)) begin
            rem_d   = len;
            gap_d   = gap;
            state_d = SEND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEND: begin
        val_d = 1'b1;
        dat_d = mem_q[rd_ptr_q];
        rem_d = rem_q - (AW+1)'(1);
        if (rem_d == '0) begin
          state_d = DONE;
        end else if (gap_q != 4'd0) begin
          state_d   = GAP;
          gap_cnt_d = gap_q;
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q - 4'd1;
        if (gap_cnt_d == 4'd0) state_d = SEND;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // busy also covers the cycle where done is shown, so a start there is ignored.
    busy_d = (state_d != IDLE) || (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rem_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      full_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      val_q     <= 1'b0;
      dat_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      rem_q     <= rem_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      full_q    <= full_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
      val_q     <= val_d;
      dat_q     <= dat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_dat;
  end

  assign full  = full_q;
  assign level = level_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;
  assign ovf   = ovf_q;
  assign dat_o = dat_q;
  assign val_o = val_q;

endmodule

// File: tb/tb_stream_burst_tx.sv
// Directed bench for stream_burst_tx: a queue/timeline model checked every
// cycle, plus literal expectations for each scenario.
module tb_stream_burst_tx;

  localparam int WORD_LEN = 8;
  localparam int DEPTH    = 16;
  localparam int AW       = 4;

  logic                clk = 1'b0;
  logic                rst, wr_en, start;
  logic [WORD_LEN-1:0] wr_dat;
  logic [AW:0]         len;
  logic [3:0]          gap;
  logic                full, busy, done, err, ovf, val_o;
  logic [AW:0]         level;
  logic [WORD_LEN-1:0] dat_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stream_burst_tx #(.WORD_LEN(WORD_LEN), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_dat(wr_dat), .full(full),
    .level(level), .start(start), .len(len), .gap(gap), .busy(busy),
    .done(done), .err(err), .ovf(ovf), .dat_o(dat_o), .val_o(val_o)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: buffer is a plain queue, burst timing is arithmetic on edge offsets.
  logic [7:0] fifo[$];
  int   edge_n = 0;
  bit   active = 0;
  int   bk, bl, bg, done_off;
  logic e_val = 0, e_done = 0, e_err = 0, e_busy = 0, e_ovf = 0, e_full = 0;
  logic [7:0] e_dat = 0;
  int   e_level = 0;

  always @(posedge clk) begin
    int pre, o;
    bit popped;
    edge_n++;
    pre    = fifo.size();
    popped = 0;
    e_val  = 0; e_dat = 0; e_done = 0; e_err = 0;
    if (rst) begin
      fifo.delete();
      active = 0;
      e_busy = 0;
      e_ovf  = 0;
    end else begin
      if (active) begin
        o = edge_n - bk;
        if (o >= 1 && ((o - 1) % (bg + 1)) == 0 && ((o - 1) / (bg + 1)) < bl) begin
          popped = 1;
          e_val  = 1;
          e_dat  = fifo[0];
        end
        if (o == done_off) e_done = 1;
      end
      if (start && !e_busy) begin
        if (len >= 1 && int'(len) <= pre) begin
          active   = 1;
          bk       = edge_n;
          bl       = int'(len);
          bg       = int'(gap);
          done_off = (bl - 1) * (bg + 1) + 2;
        end else begin
          e_err = 1;
        end
      end
      if (popped) void'(fifo.pop_front());
      if (wr_en) begin
        if (pre < DEPTH || popped) fifo.push_back(wr_dat);
        else e_ovf = 1;
      end
      e_busy = active && ((edge_n - bk) <= done_off);
    end
    e_level = fifo.size();
    e_full  = (e_level == DEPTH);
  end

  always @(negedge clk) begin
    if (edge_n > 0) begin
      checkOutput("val_o", val_o, e_val);
      checkOutput("dat_o", dat_o, e_dat);
      checkOutput("done", done, e_done);
      checkOutput("err", err, e_err);
      checkOutput("busy", busy, e_busy);
      checkOutput("level", level, e_level);
      checkOutput("full", full, e_full);
      checkOutput("ovf", ovf, e_ovf);
    end
  end

  // Stream capture and pulse counters used by the literal checks.
  logic [7:0] got[$];
  logic [7:0] want[$];
  int done_cnt = 0, err_cnt = 0, val_cnt = 0;

  always @(negedge clk) begin
    if (val_o === 1'b1) begin
      got.push_back(dat_o);
      val_cnt++;
    end
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  task automatic check_stream(input string name);
    checkOutput({name, "_count"}, got.size(), want.size());
    for (int i = 0; i < got.size() && i < want.size(); i++)
      checkOutput({name, "_data"}, got[i], want[i]);
  endtask

  task automatic applyStimulus(input logic w, input logic [7:0] d, input logic s,
                               input logic [AW:0] l, input logic [3:0] g, input logic r);
    @(negedge clk);
    wr_en = w; wr_dat = d; start = s; len = l; gap = g; rst = r;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 8'h00, 1'b0, '0, 4'd0, 1'b0);
  endtask

  task automatic write_word(input logic [7:0] d);
    applyStimulus(1'b1, d, 1'b0, '0, 4'd0, 1'b0);
  endtask

  task automatic send(input logic [AW:0] l, input logic [3:0] g);
    applyStimulus(1'b0, 8'h00, 1'b1, l, g, 1'b0);
  endtask

  initial begin
    logic [7:0] pat [10];
    logic [7:0] vbits, dbits;
    pat = '{8'd5, 8'd3, 8'd4, 8'd2, 8'd1, 8'd5, 8'd3, 8'd4, 8'd2, 8'd1};
    rst = 1'b1; wr_en = 1'b0; wr_dat = '0; start = 1'b0; len = '0; gap = '0;
    applyStimulus(1'b0, 8'h00, 1'b0, '0, 4'd0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, '0, 4'd0, 1'b1);
    idle(1);
    checkOutput("reset_level", level, 0);
    checkOutput("reset_val", val_o, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_ovf", ovf, 0);

    // Filter stimulus replay
    for (int i = 0; i < 10; i++) write_word(pat[i]);
    idle(1);
    got.delete(); done_cnt = 0;
    send(5'd10, 4'd0);
    idle(14);
    want.delete();
    for (int i = 0; i < 10; i++) want.push_back(pat[i]);
    check_stream("replay");
    checkOutput("replay_level", level, 0);
    checkOutput("replay_done_count", done_cnt, 1);

    // Gap spacing
    got.delete();
    write_word(8'h11); write_word(8'h22); write_word(8'h33);
    idle(1);
    send(5'd3, 4'd2);
    vbits = '0; dbits = '0;
    for (int i = 0; i < 9; i++) begin
      idle(1);
      if (i >= 1) begin
        vbits[i-1] = val_o;
        dbits[i-1] = done;
      end
    end
    idle(2);
    want = '{8'h11, 8'h22, 8'h33};
    check_stream("gap");
    checkOutput("gap_val_pattern", vbits, 8'h49);
    checkOutput("gap_done_pattern", dbits, 8'h80);

    // Rejection, including starts while busy and during the done cycle
    err_cnt = 0; val_cnt = 0;
    write_word(8'h5A); write_word(8'hA5);
    idle(1);
    send(5'd3, 4'd0); idle(1);
    send(5'd0, 4'd0); idle(1);
    send(5'd20, 4'd0); idle(3);
    checkOutput("rej_err_count", err_cnt, 3);
    checkOutput("rej_val_count", val_cnt, 0);
    checkOutput("rej_level", level, 2);
    got.delete();
    send(5'd2, 4'd0);
    send(5'd1, 4'd0);
    idle(2);
    send(5'd1, 4'd0);
    idle(4);
    want = '{8'h5A, 8'hA5};
    check_stream("drain");
    checkOutput("busy_ignore_err_count", err_cnt, 3);

    // Full / overflow / pointer wrap
    got.delete();
    for (int i = 0; i < 16; i++) write_word(8'(i));
    write_word(8'hAA);
    idle(1);
    checkOutput("wrap_full", full, 1);
    checkOutput("wrap_ovf", ovf, 1);
    checkOutput("wrap_level16", level, 16);
    send(5'd8, 4'd0);
    idle(11);
    want.delete();
    for (int i = 0; i < 8; i++) want.push_back(8'(i));
    check_stream("wrap_first");
    checkOutput("wrap_level8", level, 8);
    checkOutput("wrap_not_full", full, 0);
    got.delete();
    for (int i = 16; i < 24; i++) write_word(8'(i));
    idle(1);
    checkOutput("wrap_refull", full, 1);
    send(5'd16, 4'd0);
    idle(19);
    want.delete();
    for (int i = 8; i < 24; i++) want.push_back(8'(i));
    check_stream("wrap_second");
    checkOutput("wrap_level0", level, 0);
    checkOutput("wrap_ovf_sticky", ovf, 1);

    // Concurrent writes during a burst
    got.delete();
    for (int i = 0; i < 4; i++) write_word(8'h40 + 8'(i));
    idle(1);
    send(5'd4, 4'd0);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) write_word(8'h50 + 8'(i));
      else idle(1);
      checkOutput("conc_level", level, 4);
    end
    idle(4);
    want = '{8'h40, 8'h41, 8'h42, 8'h43};
    check_stream("conc_first");
    got.delete();
    send(5'd4, 4'd0);
    idle(7);
    want = '{8'h50, 8'h51, 8'h52, 8'h53};
    check_stream("conc_second");

    // Reset mid-burst
    got.delete(); done_cnt = 0;
    for (int i = 0; i < 8; i++) write_word(8'h80 + 8'(i));
    idle(1);
    send(5'd8, 4'd0);
    idle(3);
    applyStimulus(1'b0, 8'h00, 1'b0, '0, 4'd0, 1'b1);
    checkOutput("pre_rst_val", val_o, 1);
    checkOutput("pre_rst_dat", dat_o, 8'h82);
    idle(1);
    checkOutput("rst_val", val_o, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_ovf", ovf, 0);
    idle(5);
    checkOutput("rst_no_done", done_cnt, 0);
    want = '{8'h80, 8'h81, 8'h82};
    check_stream("rst_partial");
    got.delete();
    write_word(8'h99);
    idle(1);
    send(5'd1, 4'd0);
    idle(4);
    want = '{8'h99};
    check_stream("post_rst");
    checkOutput("post_rst_done", done_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
